// File: rtl/udl_bounce_cnt.sv
// Up/down loadable counter with a programmable [lo_lim, hi_lim] window and
// wrap, saturate and bounce (ping-pong) step modes.
module udl_bounce_cnt #(
  parameter int unsigned N_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pl,
  input  logic             d_nu,
  input  logic [1:0]       mode,
  input  logic [N_BIT-1:0] lo_lim,
  input  logic [N_BIT-1:0] hi_lim,
  input  logic [N_BIT-1:0] pin,
  output logic [N_BIT-1:0] cnt,
  output logic             dir,
  output logic             tc,
  output logic             lim_err
);

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [N_BIT-1:0] cnt_d;
  logic             dir_d;
  logic             tc_d;
  logic [N_BIT-1:0] load_val;
  logic [N_BIT-1:0] cnt_inc;
  logic [N_BIT-1:0] cnt_dec;
  logic             dir_eff;
  logic             at_hi;
  logic             at_lo;
  logic             above;
  logic             below;

  assign mode_sel = mode_e'(mode);
  assign lim_err  = (lo_lim > hi_lim);

  assign above   = (cnt > hi_lim);
  assign below   = (cnt < lo_lim);
  assign at_hi   = (cnt == hi_lim);
  assign at_lo   = (cnt == lo_lim);
  // +/-1 is only selected strictly inside the window, so it never wraps modulo 2^N_BIT
  assign cnt_inc = cnt + N_BIT'(1);
  assign cnt_dec = cnt - N_BIT'(1);
  assign dir_eff = (mode_sel == MODE_BOUNCE) ? dir : d_nu;

  // Load value clamped into the window
  always_comb begin
    load_val = pin;
    if (pin < lo_lim) begin
      load_val = lo_lim;
    end else if (pin > hi_lim) begin
      load_val = hi_lim;
    end
  end

  // Next-state: lim_err > pl > en step > hold
  always_comb begin
    cnt_d = cnt;
    dir_d = dir;
    tc_d  = 1'b0;
    if (!lim_err) begin
      if (pl) begin
        cnt_d = load_val;
        dir_d = d_nu;
      end else if (en) begin
        if (above) begin
          cnt_d = hi_lim;
        end else if (below) begin
          cnt_d = lo_lim;
        end else begin
          case (mode_sel)
            MODE_SAT: begin
              dir_d = d_nu;
              if (dir_eff ? at_lo : at_hi) begin
                tc_d = 1'b1;
              end else begin
                cnt_d = dir_eff ? cnt_dec : cnt_inc;
              end
            end
            MODE_BOUNCE: begin
              if (at_lo && at_hi) begin
                dir_d = ~dir;
                tc_d  = 1'b1;
              end else if (!dir && at_hi) begin
                cnt_d = hi_lim - N_BIT'(1);
                dir_d = 1'b1;
                tc_d  = 1'b1;
              end else if (dir && at_lo) begin
                cnt_d = lo_lim + N_BIT'(1);
                dir_d = 1'b0;
                tc_d  = 1'b1;
              end else begin
                cnt_d = dir ? cnt_dec : cnt_inc;
              end
            end
            default: begin
              dir_d = d_nu;
              if (!dir_eff && at_hi) begin
                cnt_d = lo_lim;
                tc_d  = 1'b1;
              end else if (dir_eff && at_lo) begin
                cnt_d = hi_lim;
                tc_d  = 1'b1;
              end else begin
                cnt_d = dir_eff ? cnt_dec : cnt_inc;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      dir <= 1'b0;
      tc  <= 1'b0;
    end else begin
      cnt <= cnt_d;
      dir <= dir_d;
      tc  <= tc_d;
    end
  end

endmodule

// File: tb/tb_udl_bounce_cnt.sv
// Scoreboard bench for udl_bounce_cnt: driver queues hand-computed results,
// monitor pops one per clock and compares.
module tb_udl_bounce_cnt;

  localparam int unsigned N_BIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             pl;
  logic             d_nu;
  logic [1:0]       mode;
  logic [N_BIT-1:0] lo_lim;
  logic [N_BIT-1:0] hi_lim;
  logic [N_BIT-1:0] pin;
  logic [N_BIT-1:0] cnt;
  logic             dir;
  logic             tc;
  logic             lim_err;

  typedef struct {
    logic [N_BIT-1:0] cnt;
    logic             dir;
    logic             tc;
    logic             lerr;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  udl_bounce_cnt #(.N_BIT(N_BIT)) dut (
    .clk(clk), .rst(rst), .en(en), .pl(pl), .d_nu(d_nu), .mode(mode),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .pin(pin),
    .cnt(cnt), .dir(dir), .tc(tc), .lim_err(lim_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [N_BIT-1:0] act, input logic [N_BIT-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    end
  endtask

  // Monitor: one expected result per clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, "cnt", cnt, e.cnt);
        chk(e.name, "dir", N_BIT'(dir), N_BIT'(e.dir));
        chk(e.name, "tc", N_BIT'(tc), N_BIT'(e.tc));
        chk(e.name, "lim_err", N_BIT'(lim_err), N_BIT'(e.lerr));
      end
    end
  end

  // Drive one cycle of inputs and queue the result expected after the next edge
  task automatic cyc(input logic r, input logic e, input logic p, input logic dn,
                     input logic [1:0] m, input int lo, input int hi, input int pv,
                     input int ec, input logic ed, input logic et, input logic el,
                     input string name);
    exp_t x;
    @(negedge clk);
    rst    = r;
    en     = e;
    pl     = p;
    d_nu   = dn;
    mode   = m;
    lo_lim = N_BIT'(lo);
    hi_lim = N_BIT'(hi);
    pin    = N_BIT'(pv);
    x.cnt  = N_BIT'(ec);
    x.dir  = ed;
    x.tc   = et;
    x.lerr = el;
    x.name = name;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; pl = 1'b1; d_nu = 1'b1; mode = 2'b00;
    lo_lim = '0; hi_lim = '1; pin = 4'd5;

    // reset beats pl/en, then hold
    cyc(0,1,1,1,2'b00, 0,15, 7,  0,0,0,0, "reset");
    cyc(1,0,0,0,2'b00, 0,15, 7,  0,0,0,0, "reset_hold");

    // wrap 3..6
    cyc(1,0,1,0,2'b00, 3,6, 3,   3,0,0,0, "wrap_load");
    cyc(1,1,0,0,2'b00, 3,6, 0,   4,0,0,0, "wrap_up4");
    cyc(1,1,0,0,2'b00, 3,6, 0,   5,0,0,0, "wrap_up5");
    cyc(1,1,0,0,2'b00, 3,6, 0,   6,0,0,0, "wrap_up6");
    cyc(1,1,0,0,2'b00, 3,6, 0,   3,0,1,0, "wrap_up_wrap");
    cyc(1,1,0,1,2'b00, 3,6, 0,   6,1,1,0, "wrap_dn_wrap");
    cyc(1,1,0,1,2'b00, 3,6, 0,   5,1,0,0, "wrap_dn5");

    // saturate 2..5
    cyc(1,0,1,0,2'b01, 2,5, 4,   4,0,0,0, "sat_load");
    cyc(1,1,0,0,2'b01, 2,5, 0,   5,0,0,0, "sat_up5");
    cyc(1,1,0,0,2'b01, 2,5, 0,   5,0,1,0, "sat_hold1");
    cyc(1,1,0,0,2'b01, 2,5, 0,   5,0,1,0, "sat_hold2");
    cyc(1,0,1,1,2'b01, 2,5, 2,   2,1,0,0, "sat_load_lo");
    cyc(1,1,0,1,2'b01, 2,5, 0,   2,1,1,0, "sat_dn_hold");

    // bounce 0..3, d_nu ignored while stepping
    cyc(1,0,1,0,2'b10, 0,3, 0,   0,0,0,0, "bnc_load");
    cyc(1,1,0,1,2'b10, 0,3, 0,   1,0,0,0, "bnc_1");
    cyc(1,1,0,1,2'b10, 0,3, 0,   2,0,0,0, "bnc_2");
    cyc(1,1,0,1,2'b10, 0,3, 0,   3,0,0,0, "bnc_3");
    cyc(1,1,0,0,2'b10, 0,3, 0,   2,1,1,0, "bnc_turn_hi");
    cyc(1,1,0,0,2'b10, 0,3, 0,   1,1,0,0, "bnc_dn1");
    cyc(1,1,0,0,2'b10, 0,3, 0,   0,1,0,0, "bnc_dn0");
    cyc(1,1,0,1,2'b10, 0,3, 0,   1,0,1,0, "bnc_turn_lo");

    // load clamp 4..9
    cyc(1,0,1,0,2'b00, 4,9, 12,  9,0,0,0, "clamp_hi");
    cyc(1,0,1,0,2'b00, 4,9, 1,   4,0,0,0, "clamp_lo");
    cyc(1,1,1,1,2'b00, 4,9, 7,   7,1,0,0, "load_wins");

    // runtime limit changes
    cyc(1,0,1,0,2'b00, 4,9, 8,   8,0,0,0, "lim_load8");
    cyc(1,1,0,1,2'b00, 4,5, 0,   5,0,0,0, "lim_above");
    cyc(1,1,0,1,2'b00, 7,5, 0,   5,0,0,1, "lim_err_en");
    cyc(1,0,1,1,2'b00, 7,5, 6,   5,0,0,1, "lim_err_pl");
    cyc(1,1,0,1,2'b00, 7,9, 0,   7,0,0,0, "lim_below");

    // bounce with lo==hi
    cyc(1,0,1,0,2'b10, 4,4, 4,   4,0,0,0, "eq_load");
    cyc(1,1,0,0,2'b10, 4,4, 0,   4,1,1,0, "eq_step1");
    cyc(1,1,0,0,2'b10, 4,4, 0,   4,0,1,0, "eq_step2");
    cyc(1,1,0,0,2'b10, 4,4, 0,   4,1,1,0, "eq_step3");
    cyc(1,0,0,0,2'b10, 4,4, 0,   4,1,0,0, "eq_idle");

    // full range, reserved mode acts as wrap
    cyc(1,0,1,0,2'b11, 0,15, 15, 15,0,0,0, "full_load");
    cyc(1,1,0,0,2'b11, 0,15, 0,  0,0,1,0,  "full_up_wrap");
    cyc(1,1,0,1,2'b11, 0,15, 0,  15,1,1,0, "full_dn_wrap");
    cyc(1,1,0,1,2'b11, 0,15, 0,  14,1,0,0, "full_dn14");

    // switch to bounce mid-run: keeps cnt and dir register
    cyc(1,1,0,0,2'b10, 0,15, 0,  13,1,0,0, "mode_switch");
    cyc(0,1,1,0,2'b10, 0,15, 9,  0,0,0,0,  "reset_mid");
    cyc(1,0,0,0,2'b10, 0,15, 9,  0,0,0,0,  "post_reset");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
